// File: rtl/ysyx_23060240_arb_pkg.sv
// rtl/ysyx_23060240_arb_pkg.sv - shared constants for the IFU/LSU memory arbiter
package ysyx_23060240_arb_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   // LSU marked as most recent owner so the IFU wins the first tie after reset
   localparam logic LAST_RST = OWN_LSU;

   function automatic logic other_owner(input logic own);
      return (own == OWN_IFU) ? OWN_LSU : OWN_IFU;
   endfunction

endpackage

// File: rtl/ysyx_23060240_rr_pick.sv
// rtl/ysyx_23060240_rr_pick.sv - two-way round-robin pick, purely combinational
module ysyx_23060240_rr_pick
   import ysyx_23060240_arb_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic last,
   output logic gnt_valid,
   output logic gnt_idx
);

   always_comb begin
      gnt_valid = valid0 | valid1;
      if (valid0 && valid1) begin
         gnt_idx = other_owner(last);
      end else if (valid1) begin
         gnt_idx = OWN_LSU;
      end else begin
         gnt_idx = OWN_IFU;
      end
   end

endmodule

// File: rtl/ysyx_23060240_mem_arbiter.sv
// rtl/ysyx_23060240_mem_arbiter.sv - IFU/LSU to single memory port arbiter
// One transaction at a time: grant, latch payload, issue, route response to owner.
module ysyx_23060240_mem_arbiter
   import ysyx_23060240_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ADDR_W-1:0]     ifu_addr,
   output logic                  ifu_resp_valid,
   input  logic                  ifu_resp_ready,
   output logic [DATA_W-1:0]     ifu_rdata,

   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [ADDR_W-1:0]     lsu_addr,
   input  logic                  lsu_wen,
   input  logic [DATA_W-1:0]     lsu_wdata,
   input  logic [DATA_W/8-1:0]   lsu_wmask,
   output logic                  lsu_resp_valid,
   input  logic                  lsu_resp_ready,
   output logic [DATA_W-1:0]     lsu_rdata,

   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_wen,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wmask,
   input  logic                  mem_resp_valid,
   output logic                  mem_resp_ready,
   input  logic [DATA_W-1:0]     mem_rdata
);

   logic [1:0]          state;
   logic                owner;
   logic                last;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wmask_q;

   logic gnt_valid;
   logic gnt_idx;
   logic idle;
   logic in_resp;
   logic owner_resp_ready;
   logic resp_fire;

   ysyx_23060240_rr_pick u_pick (
      .valid0    (ifu_req_valid),
      .valid1    (lsu_req_valid),
      .last      (last),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Readies are gated by rst so nothing is granted while reset is held
   assign idle          = (state == IDLE) && rst;
   assign ifu_req_ready = idle && gnt_valid && (gnt_idx == OWN_IFU);
   assign lsu_req_ready = idle && gnt_valid && (gnt_idx == OWN_LSU);

   assign mem_req_valid = (state == REQ);
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;

   assign in_resp          = (state == RESP);
   assign owner_resp_ready = (owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
   assign mem_resp_ready   = in_resp && owner_resp_ready;
   assign resp_fire        = mem_resp_valid && mem_resp_ready;

   assign ifu_resp_valid = in_resp && (owner == OWN_IFU) && mem_resp_valid;
   assign lsu_resp_valid = in_resp && (owner == OWN_LSU) && mem_resp_valid;
   assign ifu_rdata      = (in_resp && (owner == OWN_IFU)) ? mem_rdata : '0;
   assign lsu_rdata      = (in_resp && (owner == OWN_LSU)) ? mem_rdata : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         owner <= OWN_IFU;
         last  <= LAST_RST;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  owner <= gnt_idx;
                  state <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state <= RESP;
               end
            end
            RESP: begin
               if (resp_fire) begin
                  last  <= owner;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Payload is captured at grant; the IFU never writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (idle && gnt_valid) begin
         if (gnt_idx == OWN_LSU) begin
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            wdata_q <= lsu_wdata;
            wmask_q <= lsu_wmask;
         end else begin
            addr_q  <= ifu_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// tb/tb_ysyx_23060240_mem_arbiter.sv - directed scoreboard bench for the memory arbiter
module tb_ysyx_23060240_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   always #5 clk = ~clk;

   ysyx_23060240_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        owner;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] data;
   } txn_t;

   int   nvec = 0;
   int   nbad = 0;
   int   cyc = 0;
   txn_t sb[$];
   int   gnt_log[$];
   int   gnt_cyc[$];
   int   resp_cyc[$];
   int   ph = 0;
   logic m_last = 1'b1;
   int   ifu_pend = 0, lsu_pend = 0;
   logic adv_ifu = 1'b0, adv_lsu = 1'b0;
   int   stall = 0, lsu_hold = 0;
   logic force_resp = 1'b0, mem_acc = 1'b0, resp_done = 1'b0;
   logic [31:0] acc_addr = '0;
   int   lsu_rdy_cnt = 0, req_cnt = 0, resp_cnt = 0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_A5A5);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic exp_v, exp_l, own;
      txn_t t;
      @(negedge clk);
      cyc++;
      if (adv_ifu) begin ifu_addr += 32'd4; adv_ifu = 1'b0; end
      if (adv_lsu) begin
         lsu_addr += 32'd4; lsu_wdata += 32'h1111_1111; lsu_wen = ~lsu_wen; lsu_wmask += 4'd1;
         adv_lsu = 1'b0;
      end
      ifu_req_valid = (ifu_pend > 0);
      lsu_req_valid = (lsu_pend > 0);
      if (resp_done) begin mem_resp_valid = 1'b0; resp_done = 1'b0; end
      if (mem_acc) begin
         mem_resp_valid = 1'b1; mem_rdata = mem_fn(acc_addr); mem_acc = 1'b0;
      end else if (ph != 2) begin
         mem_resp_valid = force_resp;
         mem_rdata = force_resp ? 32'hBAD0_BAD0 : 32'h0;
      end
      if (mem_req_valid) begin
         if (stall > 0) begin mem_req_ready = 1'b0; stall--; end
         else mem_req_ready = 1'b1;
      end else mem_req_ready = 1'b0;
      if (ph == 2 && lsu_hold > 0) begin lsu_resp_ready = 1'b0; lsu_hold--; end
      else lsu_resp_ready = 1'b1;
      ifu_resp_ready = 1'b1;
      #1;
      exp_v = (ph == 0) && (ifu_req_valid || lsu_req_valid);
      exp_l = (ifu_req_valid && lsu_req_valid) ? ~m_last : lsu_req_valid;
      chk("ifu_req_ready", ifu_req_ready, exp_v && !exp_l);
      chk("lsu_req_ready", lsu_req_ready, exp_v && exp_l);
      chk("mem_req_valid", mem_req_valid, ph == 1);
      if (lsu_req_ready) lsu_rdy_cnt++;
      if (ph != 2) begin
         chk("mem_resp_ready_off", mem_resp_ready, 0);
         chk("ifu_resp_valid_off", ifu_resp_valid, 0);
         chk("lsu_resp_valid_off", lsu_resp_valid, 0);
         chk("ifu_rdata_off", ifu_rdata, 0);
         chk("lsu_rdata_off", lsu_rdata, 0);
      end
      if (ph == 2) begin
         own = sb[0].owner;
         if (mem_resp_valid) resp_cnt++;
         chk("mem_resp_ready", mem_resp_ready, own ? lsu_resp_ready : ifu_resp_ready);
         chk("ifu_resp_valid", ifu_resp_valid, !own && mem_resp_valid);
         chk("lsu_resp_valid", lsu_resp_valid, own && mem_resp_valid);
         if (!own && ifu_resp_valid) chk("ifu_rdata", ifu_rdata, sb[0].data);
         if (own && lsu_resp_valid && !sb[0].wen) chk("lsu_rdata", lsu_rdata, sb[0].data);
         chk("nonowner_rdata", own ? ifu_rdata : lsu_rdata, 0);
         if (mem_resp_valid && mem_resp_ready) begin
            t = sb.pop_front();
            m_last = t.owner;
            resp_cyc.push_back(cyc);
            resp_done = 1'b1;
            ph = 0;
         end
      end else if (ph == 1) begin
         req_cnt++;
         chk("mem_addr", mem_addr, sb[0].addr);
         chk("mem_wen", mem_wen, sb[0].wen);
         chk("mem_wmask", mem_wmask, sb[0].wmask);
         if (sb[0].owner) chk("mem_wdata", mem_wdata, sb[0].wdata);
         if (mem_req_ready) begin mem_acc = 1'b1; acc_addr = mem_addr; ph = 2; end
      end else if (exp_v) begin
         t.owner = exp_l;
         t.addr  = exp_l ? lsu_addr : ifu_addr;
         t.wen   = exp_l ? lsu_wen : 1'b0;
         t.wdata = exp_l ? lsu_wdata : 32'h0;
         t.wmask = exp_l ? lsu_wmask : 4'h0;
         t.data  = mem_fn(t.addr);
         sb.push_back(t);
         gnt_log.push_back(int'(exp_l));
         gnt_cyc.push_back(cyc);
         if (exp_l) begin lsu_pend--; adv_lsu = 1'b1; end
         else begin ifu_pend--; adv_ifu = 1'b1; end
         ph = 1;
      end
   endtask

   task automatic run(input string tag, input int budget);
      int n;
      logic done;
      n = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         cycle();
         n++;
         done = (ifu_pend == 0) && (lsu_pend == 0) && (ph == 0) && (sb.size() == 0);
      end
      if (!done) chk({"timeout_", tag}, done, 1);
   endtask

   task automatic reset_model();
      ph = 0; m_last = 1'b1; sb.delete();
      mem_acc = 1'b0; resp_done = 1'b0; stall = 0; lsu_hold = 0;
      ifu_pend = 0; lsu_pend = 0; adv_ifu = 1'b0; adv_lsu = 1'b0;
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
   endtask

   task automatic clear_logs();
      gnt_log.delete(); gnt_cyc.delete(); resp_cyc.delete();
      lsu_rdy_cnt = 0; req_cnt = 0; resp_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
      lsu_addr = 32'h8000_1000; lsu_wen = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
      ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      #2;
      chk("rst_ifu_req_ready", ifu_req_ready, 0);
      chk("rst_lsu_req_ready", lsu_req_ready, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_resp_ready", mem_resp_ready, 0);
      chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
      chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      reset_model();
      @(negedge clk);
      rst = 1'b1;

      // lone IFU fetch
      clear_logs();
      ifu_addr = 32'h8000_0000; ifu_pend = 1;
      run("lone_ifu", 20);
      chk("lone_ifu_grants", gnt_log.size(), 1);
      chk("lone_ifu_owner", gnt_log[0], 0);
      chk("lone_ifu_latency", resp_cyc[0] - gnt_cyc[0], 2);

      // contention starting from reset
      @(negedge clk); rst = 1'b0; #1; reset_model();
      @(negedge clk); rst = 1'b1;
      clear_logs();
      ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
      lsu_wdata = 32'h0101_0101; lsu_wmask = 4'h1;
      ifu_pend = 3; lsu_pend = 3;
      run("contention", 60);
      chk("contention_grants", gnt_log.size(), 6);
      for (int i = 0; i < gnt_log.size(); i++) chk($sformatf("alt_%0d", i), gnt_log[i], i % 2);
      for (int i = 1; i < gnt_cyc.size(); i++)
         chk($sformatf("turnaround_%0d", i), gnt_cyc[i] - gnt_cyc[i-1], 3);

      // LSU store with memory stalling the request
      clear_logs();
      lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3; lsu_wen = 1'b1;
      stall = 4; lsu_pend = 1;
      run("store", 30);
      chk("store_ready_pulses", lsu_rdy_cnt, 1);
      chk("store_req_cycles", req_cnt, 5);

      // LSU load with response backpressure
      clear_logs();
      lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_wmask = 4'h0;
      lsu_hold = 3; lsu_pend = 1;
      run("backpressure", 30);
      chk("bp_resp_cycles", resp_cnt, 4);

      // reset while the request is pending at memory
      clear_logs();
      lsu_addr = 32'h8000_4000; lsu_wen = 1'b1; lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'hC;
      stall = 10; lsu_pend = 1;
      cycle(); cycle();
      @(negedge clk);
      #1 chk("req_before_reset", mem_req_valid, 1);
      #1 rst = 1'b0; mem_resp_valid = 1'b1;
      #1 chk("req_async_drop", mem_req_valid, 0);
      chk("rst_mid_ifu_resp", ifu_resp_valid, 0);
      chk("rst_mid_lsu_resp", lsu_resp_valid, 0);
      reset_model();
      @(negedge clk); rst = 1'b1;

      // spurious responses while idle, then a tie must go to the IFU
      clear_logs();
      force_resp = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      ifu_addr = 32'h8000_0200; ifu_pend = 1;
      lsu_addr = 32'h8000_5000; lsu_wen = 1'b0; lsu_pend = 1;
      run("after_reset", 30);
      force_resp = 1'b0;
      chk("after_reset_grants", gnt_log.size(), 2);
      chk("after_reset_first", gnt_log[0], 0);
      chk("after_reset_second", gnt_log[1], 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/ysyx_23060240_mem_arbiter.md
# ysyx_23060240_mem_arbiter

Two-master, one-slave memory arbiter sitting between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) on one side and the single shared memory port (SRAM model or bus bridge) on the other. It takes over from the direct DPI fetch path once the core moves to handshaked memory access. It grants one transaction at a time with 2-way round-robin, latches the request, issues it to memory, and routes the response back to the owner.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; the write mask is DATA_W/8 bits
- clk  in  1  core clock; all state is on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_addr  in  ADDR_W  IFU fetch address (the PC)
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake
- ifu_rdata  out  DATA_W  fetched instruction word
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W;  lsu_wen  in  1 (1 = write);  lsu_wdata  in  DATA_W;  lsu_wmask  in  DATA_W/8
- lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake
- lsu_rdata  out  DATA_W  load data; don't-care for writes
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  payload to memory
- mem_resp_valid / mem_resp_ready  in / out  1  memory response handshake
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, REQ, RESP. `owner` register: 0 = IFU, 1 = LSU. `last` register holds the most recent owner.
- IDLE:
  - If exactly one master has req_valid, grant it.
  - If both are valid, grant the one that is not `last`.
  - The granted master's req_ready = 1 in that same cycle; ready is combinational on the valids and is allowed to depend on them.
  - On that edge: latch addr/wen/wdata/wmask, set `owner`, go to REQ.
  - IFU payload forces wen = 0 and wmask = 0.
- REQ:
  - mem_req_valid = 1 with the latched payload.
  - Stay in REQ until mem_req_ready = 1, then go to RESP.
- RESP:
  - mem_resp_ready = owner's resp_ready; owner's resp_valid = mem_resp_valid; owner's rdata = mem_rdata.
  - On the mem_resp_valid & resp_ready handshake: `last` <= `owner`, go to IDLE.
- Non-owner outputs: req_ready = 0, resp_valid = 0, rdata = 0.
- Outside RESP: mem_resp_ready = 0; any mem_resp_valid is ignored.
- Outside REQ: mem_req_valid = 0.
- Masters must hold req_valid and the payload stable until req_ready. The arbiter does not check this; latching at grant makes later payload changes harmless.
- Reset (asynchronous, active-low):
  - State = IDLE, `last` = LSU, so the IFU wins the first tie.
  - All payload registers = 0; all valid/ready outputs = 0.
  - Reset mid-transaction drops the transaction immediately; no response is delivered.

## Timing
- Grant to mem_req_valid: 1 cycle. A grant at edge N gives mem_req_valid high during cycle N+1.
- Minimum turnaround: 3 cycles per transaction, with memory ready at once and responding the next cycle. Back-to-back transactions therefore start every 3 cycles.
- There is no pipelining: at most one outstanding transaction.
- Fairness: under continuous contention, grants strictly alternate IFU, LSU, IFU, …
- Starvation bound: at most one foreign transaction between two grants to the same waiting master.
- mem_resp_valid in the same cycle as the mem_req_ready acceptance is not consumed; it is handled in RESP from the next cycle on.

## Structure
- Shared package ysyx_23060240_arb_pkg:
  - state localparams: IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2
  - owner constants: OWN_IFU = 1'b0, OWN_LSU = 1'b1
  - the reset value of `last`
- One sub-module, ysyx_23060240_rr_pick:
  - inputs: two valids and `last`
  - outputs: grant-valid and grant-index, combinational
  - reused later for more masters
- The top holds the FSM, the payload latches and the response mux.

## Test plan
- Lone IFU: ifu_addr = 0x80000000, memory ready at once, mem_rdata = 0x00000413 one cycle later. Required: ifu_resp_valid high in the 3rd cycle after request, ifu_rdata = 0x00000413, mem_wen = 0.
- Contention from reset: both masters valid at cycle 0. Required: IFU granted first, then LSU, then IFU (strict alternation over 6 transactions).
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 0x3, mem_req_ready held low 4 cycles. Required: mem_req_valid and the payload stay stable for all 4 cycles; lsu_req_ready pulses only once.
- Backpressure: lsu_resp_ready low 3 cycles while mem_resp_valid is high. Required: mem_resp_ready = 0 for those cycles; lsu_rdata held; the FSM remains in RESP.
- Reset asserted while in REQ. Required: mem_req_valid drops asynchronously; after release, state is IDLE, `last` = LSU, and no stale response is seen by either master.
- Spurious mem_resp_valid = 1 in IDLE. Required: ignored; both master resp_valid stay 0.
